fetch_queue_unit: RTL and testbench

- Parametrised next-generation fetch stage.
- PC generator, instruction-bus request engine (addr_ok/data_ok handshake), and an in-order instruction queue of DEPTH entries feeding decode through a valid/ready handshake.
- Handles redirects (branch/jump/exception) by flushing the queue and discarding in-flight responses.
- Detects misaligned fetch addresses and reports them as tagged queue entries, not bus requests.

---
 rtl/fetch_queue_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC generator, single-outstanding instruction-bus request
// engine and an in-order instruction queue feeding decode.
package fetch_queue_unit_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } fq_entry_t;
endpackage

module fetch_queue_unit
   import fetch_queue_unit_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
   input  logic        clk,
   input  logic        resetn,
   output ibus_req_t   ireq,
   input  ibus_resp_t  iresp,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_adel,
   output logic [31:0] out_badvaddr
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;

   state_t             state, state_n;
   logic [31:0]        fetch_pc, fetch_pc_n;
   logic [31:0]        req_addr, req_addr_n;
   logic               discard, discard_n;
   logic               push, pop, credit, inflight;
   fq_entry_t          push_ent, head;
   fq_entry_t          mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [PTR_W:0]     count;

   // A request in REQ or WAIT already owns a queue slot for its response.
   assign inflight = (state == REQ) || (state == WAIT);
   assign credit   = ({1'b0, count} + {{(PTR_W+1){1'b0}}, inflight}) < DEPTH_W;
   assign pop      = out_valid && out_ready && !redirect_valid;

   // Engine register: fetch PC, latched request address, discard flag.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= 32'h0;
         discard  <= 1'b0;
      end else begin
         state    <= state_n;
         fetch_pc <= fetch_pc_n;
         req_addr <= req_addr_n;
         discard  <= discard_n;
      end
   end

   // Next-state logic; redirect overrides everything after the normal step.
   always_comb begin
      state_n    = state;
      fetch_pc_n = fetch_pc;
      req_addr_n = req_addr;
      discard_n  = discard;
      push       = 1'b0;
      push_ent   = '{pc: req_addr, instr: iresp.data, adel: 1'b0};
      case (state)
         IDLE: begin
            if (credit) begin
               if (fetch_pc[1:0] != 2'b00) begin
                  // Misaligned PC becomes a tagged entry, never a bus request.
                  push     = 1'b1;
                  push_ent = '{pc: fetch_pc, instr: 32'h0, adel: 1'b1};
                  state_n  = HALT;
               end else begin
                  req_addr_n = fetch_pc;
                  state_n    = REQ;
               end
            end
         end
         REQ: begin
            if (iresp.addr_ok) begin
               if (!discard) fetch_pc_n = fetch_pc + 32'd4;
               if (iresp.data_ok) begin
                  push      = !discard;
                  discard_n = 1'b0;
                  state_n   = IDLE;
               end else begin
                  state_n = WAIT;
               end
            end
         end
         WAIT: begin
            if (iresp.data_ok) begin
               push      = !discard;
               discard_n = 1'b0;
               state_n   = IDLE;
            end
         end
         default: ;
      endcase
      if (redirect_valid) begin
         fetch_pc_n = redirect_pc;
         push       = 1'b0;
         case (state)
            // Bus request must stay up until accepted; mark its answer stale.
            REQ:     discard_n = !(iresp.addr_ok && iresp.data_ok);
            WAIT:    discard_n = !iresp.data_ok;
            default: state_n   = IDLE;
         endcase
      end
   end

   // Queue pointers and occupancy; a redirect empties the queue.
   always_ff @(posedge clk) begin
      if (!resetn || redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Queue storage; contents are only visible through out_valid gating.
   always_ff @(posedge clk) begin
      if (resetn && push) mem[wr_ptr] <= push_ent;
   end

   // Registered-state-only outputs, zero while the queue is empty.
   always_comb begin
      head         = mem[rd_ptr];
      out_valid    = (count != '0);
      out_pc       = out_valid ? head.pc : 32'h0;
      out_instr    = out_valid ? head.instr : 32'h0;
      out_adel     = out_valid && head.adel;
      out_badvaddr = (out_valid && head.adel) ? head.pc : 32'h0;
      ireq.valid   = (state == REQ);
      ireq.addr    = (state == REQ) ? req_addr : 32'h0;
   end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: randomized bus responder plus a queue-based
// reference of the fetch stream, with directed scenarios up front.
module tb_fetch_queue_unit;
   import fetch_queue_unit_pkg::*;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'hbfc0_0000;

   logic        clk = 1'b0;
   logic        resetn;
   ibus_req_t   ireq;
   ibus_resp_t  iresp;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid, out_ready, out_adel;
   logic [31:0] out_pc, out_instr, out_badvaddr;

   always #5 clk = ~clk;

   fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .out_adel(out_adel), .out_badvaddr(out_badvaddr)
   );

   int errs = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fdata(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   // reference: expected queue contents and fetch stream
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   ent_t        q[$];
   logic [31:0] exp_pc = '0, txn_pc = '0, held_addr = '0;
   bit          stale, held, model_on;

   // bus responder state
   int          st_min, st_max, dl_min, dl_max, bstall, bcnt;
   bit          bpend, bstall_set;
   logic [31:0] baddr = '0;

   // per-test statistics
   int          cyc = 0, n_acc, n_reqv, first_aok, first_ov;
   bit          acc_now;
   logic [31:0] acc_addr = '0, first_acc_addr = '0;

   task automatic bus_drive();
      iresp = '0;
      if (!resetn) return;
      if (bpend) begin
         if (bcnt == 0) begin
            iresp.data_ok = 1'b1;
            iresp.data    = fdata(baddr);
         end
      end else if (ireq.valid) begin
         if (!bstall_set) begin
            bstall     = $urandom_range(st_max, st_min);
            bstall_set = 1'b1;
         end
         if (bstall == 0) begin
            iresp.addr_ok = 1'b1;
            bcnt = $urandom_range(dl_max, dl_min);
            if (bcnt == 0) begin
               iresp.data_ok = 1'b1;
               iresp.data    = fdata(ireq.addr);
            end
         end
      end
   endtask

   task automatic bus_update(input bit c_rst, c_v, c_aok, c_dok, input logic [31:0] c_addr);
      if (!c_rst) begin
         bpend = 1'b0; bstall_set = 1'b0;
         return;
      end
      if (bpend) begin
         if (c_dok) bpend = 1'b0; else bcnt--;
      end else if (c_v) begin
         if (c_aok) begin
            bstall_set = 1'b0;
            if (!c_dok) begin bpend = 1'b1; baddr = c_addr; bcnt--; end
         end else bstall--;
      end
   endtask

   task automatic model_update(input bit c_rst, c_rv, c_rdy, c_v, c_aok, c_dok, c_ov,
                               input logic [31:0] c_rpc, c_addr, c_data);
      bit cont;
      if (!c_rst) begin
         q.delete(); exp_pc = RST_PC; stale = 1'b0; held = 1'b0;
         return;
      end
      if (model_on) begin
         if (held) begin
            chk("req_hold_valid", c_v, 1);
            chk("req_hold_addr", c_addr, held_addr);
         end else if (c_v) chk("credit", q.size() < DEPTH, 1);
      end
      held      = c_v && !c_aok;
      held_addr = c_addr;
      cont = (c_v && !(c_aok && c_dok)) || (bpend && !c_dok);
      if (c_v && c_aok) begin
         txn_pc = c_addr;
         if (!stale) begin
            if (model_on) chk("req_addr", c_addr, exp_pc);
            exp_pc += 32'd4;
         end
      end
      if (c_ov && c_rdy && !c_rv && q.size() > 0) void'(q.pop_front());
      if (c_dok && !stale && !c_rv) q.push_back('{pc: txn_pc, instr: c_data});
      if (c_dok) stale = 1'b0;
      if (c_rv) begin
         q.delete(); exp_pc = c_rpc; stale = cont;
      end
   endtask

   task automatic cycle();
      bit c_rst, c_rv, c_rdy, c_v, c_aok, c_dok, c_ov;
      logic [31:0] c_rpc, c_addr, c_data;
      bus_drive();
      c_rst = resetn; c_rv = redirect_valid; c_rdy = out_ready; c_v = ireq.valid;
      c_aok = iresp.addr_ok; c_dok = iresp.data_ok; c_ov = out_valid;
      c_rpc = redirect_pc; c_addr = ireq.addr; c_data = iresp.data;
      acc_now = c_rst && c_v && c_aok;
      if (acc_now) begin
         acc_addr = c_addr;
         if (n_acc == 0) begin first_acc_addr = c_addr; first_aok = cyc; end
         n_acc++;
      end
      if (c_rst && c_v) n_reqv++;
      if (c_ov && first_ov < 0) first_ov = cyc;
      @(posedge clk); #1;
      model_update(c_rst, c_rv, c_rdy, c_v, c_aok, c_dok, c_ov, c_rpc, c_addr, c_data);
      bus_update(c_rst, c_v, c_aok, c_dok, c_addr);
      if (model_on) begin
         chk("out_valid", out_valid, q.size() != 0);
         if (q.size() > 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", out_instr, q[0].instr);
            chk("out_adel", out_adel, 0);
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      repeat (2) cycle();
      resetn = 1'b1;
      n_acc = 0; n_reqv = 0; first_aok = -1; first_ov = -1;
   endtask

   task automatic wait_acc(input string tag, output logic [31:0] a);
      bit got;
      got = 1'b0; a = '0;
      for (int i = 0; i < 60 && !got; i++) begin
         cycle();
         if (acc_now) begin got = 1'b1; a = acc_addr; end
      end
      chk({tag, "_seen"}, got, 1);
   endtask

   task automatic wait_ov(input string tag);
      for (int i = 0; i < 60 && !out_valid; i++) cycle();
      chk({tag, "_seen"}, out_valid, 1);
   endtask

   initial begin
      logic [31:0] a, r;
      model_on = 1'b1; st_min = 0; st_max = 0; dl_min = 1; dl_max = 1;
      stale = 1'b0; held = 1'b0; bpend = 1'b0; bstall_set = 1'b0; bstall = 0; bcnt = 0;
      resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      iresp = '0;

      // reset state
      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ireq_valid", ireq.valid, 0);
      chk("rst_ireq_addr", ireq.addr, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_adel", out_adel, 0);
      chk("rst_badvaddr", out_badvaddr, 0);

      // sequential fetch, addr_ok same cycle, data_ok next cycle
      out_ready = 1'b1;
      repeat (30) cycle();
      chk("seq_first_addr", first_acc_addr, RST_PC);
      chk("seq_ov_latency", 32'(first_ov - first_aok), 2);
      chk("seq_n_acc", n_acc, 10);

      // queue fills to DEPTH with no extra request; one pop frees one slot
      do_reset();
      repeat (30) cycle();
      chk("full_n_acc", n_acc, DEPTH);
      chk("full_n_reqv", n_reqv, DEPTH);
      chk("full_ov", out_valid, 1);
      chk("full_head", out_pc, RST_PC);
      out_ready = 1'b1; cycle(); out_ready = 1'b0;
      repeat (20) cycle();
      chk("full_one_more", n_acc, DEPTH + 1);
      chk("full_head2", out_pc, RST_PC + 32'd4);
      out_ready = 1'b1;
      repeat (40) cycle();

      // redirect while waiting for bfc00008 data
      do_reset();
      dl_min = 3; dl_max = 3; out_ready = 1'b1; a = '0;
      for (int k = 0; k < 4 && a != 32'hbfc0_0008; k++) wait_acc("wt_acc", a);
      chk("wt_acc_8", a, 32'hbfc0_0008);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; cycle(); redirect_valid = 1'b0;
      chk("wt_flush_ov", out_valid, 0);
      wait_acc("wt_new", a);
      chk("wt_new_addr", a, 32'h8000_0100);
      wait_ov("wt_ov");
      chk("wt_out_pc", out_pc, 32'h8000_0100);

      // redirect while a request is stalled on addr_ok
      do_reset();
      st_min = 3; st_max = 3; dl_min = 1; dl_max = 1; out_ready = 1'b1;
      for (int k = 0; k < 5 && !ireq.valid; k++) cycle();
      chk("rq_req", ireq.valid, 1);
      cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; cycle(); redirect_valid = 1'b0;
      chk("rq_hold_valid", ireq.valid, 1);
      chk("rq_hold_addr", ireq.addr, RST_PC);
      wait_acc("rq_old", a);
      chk("rq_old_addr", a, RST_PC);
      wait_acc("rq_new", a);
      chk("rq_new_addr", a, 32'h8000_0200);
      wait_ov("rq_ov");
      chk("rq_out_pc", out_pc, 32'h8000_0200);

      // misaligned redirect produces one address-error entry and halts
      do_reset();
      st_min = 0; st_max = 0; out_ready = 1'b0; model_on = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; cycle(); redirect_valid = 1'b0;
      wait_ov("ad_ov");
      chk("ad_adel", out_adel, 1);
      chk("ad_badvaddr", out_badvaddr, 32'h8000_0102);
      chk("ad_instr", out_instr, 0);
      chk("ad_pc", out_pc, 32'h8000_0102);
      repeat (5) cycle();
      out_ready = 1'b1; cycle(); out_ready = 1'b0;
      repeat (5) cycle();
      chk("ad_no_req", n_reqv, 0);
      chk("ad_empty", out_valid, 0);
      model_on = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0180; cycle(); redirect_valid = 1'b0;
      wait_acc("ad_resume", a);
      chk("ad_resume_addr", a, 32'h8000_0180);
      wait_ov("ad_resume_ov");
      chk("ad_resume_pc", out_pc, 32'h8000_0180);
      chk("ad_resume_adel", out_adel, 0);

      // reset while waiting for data
      do_reset();
      dl_min = 4; dl_max = 4; out_ready = 1'b1;
      wait_acc("rw_acc", a);
      resetn = 1'b0; cycle();
      chk("rw_ov", out_valid, 0);
      chk("rw_ireq", ireq.valid, 0);
      resetn = 1'b1; n_acc = 0;
      wait_acc("rw_acc2", a);
      chk("rw_first_addr", a, RST_PC);
      repeat (20) cycle();

      // randomized traffic, redirects and back-pressure
      do_reset();
      for (int blk = 0; blk < 15; blk++) begin
         int rdy_p;
         st_min = 0; st_max = $urandom_range(3, 0);
         dl_min = 0; dl_max = $urandom_range(3, 0);
         rdy_p  = $urandom_range(4, 1);
         for (int i = 0; i < 200; i++) begin
            out_ready = ($urandom_range(3, 0) < rdy_p);
            if ($urandom_range(29, 0) == 0) begin
               r = $urandom();
               r[1:0] = 2'b00;
               if ($urandom_range(3, 0) == 0) r = 32'hffff_fff0 | (r & 32'hc);
               redirect_valid = 1'b1; redirect_pc = r;
            end else redirect_valid = 1'b0;
            cycle();
         end
      end
      redirect_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
